// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the system-RAM arbiter: FSM encodings and master ids.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic ARB_M_ADMA = 1'b0;
    localparam logic ARB_M_EXT  = 1'b1;

    function automatic arb_state_e own_state(input logic id);
        return id ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// Two-way round-robin next-owner picker: a lone requester wins outright,
// a tie goes to the master that did not own the RAM last.
module ram_arbiter_arb_rr2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = ARB_M_ADMA;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req[1]) begin
            winner = ARB_M_EXT;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Burst-granular round-robin arbiter sharing the single-port system RAM between
// the ADMA engine (master 0) and the test/CPU backdoor (master 1).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                CLK,
    input  logic                RST_L,
    input  logic [1:0]          req,
    input  logic [1:0]          rd,
    input  logic [1:0]          wr,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data_in,
    output logic                ram_write,
    output logic                ram_read,
    input  logic [DATA_W-1:0]   ram_data_out
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            last_owner_q, last_owner_d;
    logic            rd_tag_vld_q, rd_tag_vld_d;
    logic            rd_tag_id_q, rd_tag_id_d;

    logic owned, owner, other, beat;
    logic winner, any_req;

    ram_arbiter_arb_rr2 u_rr2 (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any        (any_req)
    );

    // RAM mux and grant decode, all straight from the state register.
    always_comb begin
        owned       = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
        owner       = (state_q == ARB_OWN1);
        other       = ~owner;
        gnt         = {state_q == ARB_OWN1, state_q == ARB_OWN0};
        ram_write   = owned & wr[owner];
        ram_read    = owned & rd[owner] & ~wr[owner];
        beat        = owned & (rd[owner] | wr[owner]);
        ram_address = '0;
        ram_data_in = '0;
        if (owned) begin
            ram_address = owner ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
            ram_data_in = owner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end
        rvalid = {rd_tag_vld_q & rd_tag_id_q, rd_tag_vld_q & ~rd_tag_id_q};
        rdata  = ram_data_out;
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        rd_tag_vld_d = ram_read;
        rd_tag_id_d  = owner;

        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = own_state(winner);
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (!req[owner]) begin
                    state_d = req[other] ? own_state(other) : ARB_IDLE;
                end else if (beat && (beat_cnt_q == LastBeat)) begin
                    // With nobody waiting the owner keeps the RAM and starts a fresh burst.
                    if (req[other]) begin
                        state_d = own_state(other);
                    end else begin
                        beat_cnt_d = '0;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (owned && (state_d != state_q)) begin
            beat_cnt_d   = '0;
            last_owner_d = owner;
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q      <= ARB_IDLE;
            beat_cnt_q   <= '0;
            last_owner_q <= ARB_M_EXT;
            rd_tag_vld_q <= 1'b0;
            rd_tag_id_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
            rd_tag_vld_q <= rd_tag_vld_d;
            rd_tag_id_q  <= rd_tag_id_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, read-return scoreboard,
// a mux vector table and hand-written burst/handover/reset sequences.
module tb_ram_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;

    logic                CLK = 1'b0;
    logic                RST_L = 1'b0;
    logic [1:0]          req = '0;
    logic [1:0]          rd = '0;
    logic [1:0]          wr = '0;
    logic [2*ADDR_W-1:0] addr = '0;
    logic [2*DATA_W-1:0] wdata = '0;
    logic [1:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata, ram_data_in, ram_data_out;
    logic [ADDR_W-1:0]   ram_address;
    logic                ram_write, ram_read;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)) dut (
        .CLK          (CLK),
        .RST_L        (RST_L),
        .req          (req),
        .rd           (rd),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .ram_data_out (ram_data_out)
    );

    always #5 CLK = ~CLK;

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Behavioural RAM: reloaded while reset is held, read data one cycle late.
    logic [31:0] mem [256];
    always @(posedge CLK) begin
        if (!RST_L) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        end else if (ram_write) begin
            mem[ram_address[7:0]] = ram_data_in;
        end
        if (ram_read) ram_data_out <= mem[ram_address[7:0]];
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic rd0, wr0, rd1, wr1;
        logic exp_read, exp_write;
    } vec_t;
    vec_t vecs[8];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_read(input logic id, input logic [7:0] a);
        exp_t e;
        e.id   = id;
        e.data = mem[a];
        e.cyc  = cyc_cnt + 1;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        RST_L = 1'b0;
        req = '0; rd = '0; wr = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_L = 1'b1;
        step();
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_L && rvalid != 2'b00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rvalid_id", 64'(rvalid), e.id ? 64'd2 : 64'd1);
                check("rdata", 64'(rdata), 64'(e.data));
                check("rvalid_cycle", 64'(cyc_cnt), 64'(e.cyc));
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_ram_read", 64'(ram_read), 64'd0);
        check("rst_ram_write", 64'(ram_write), 64'd0);
        check("rst_ram_address", ram_address, 64'd0);
        check("rst_ram_data_in", 64'(ram_data_in), 64'd0);
        RST_L = 1'b1;
        step();

        // 1: master 0 reads four words.
        req = 2'b01;
        @(negedge CLK);
        check("t1_gnt_latency", 64'(gnt), 64'd0);
        step();
        check("t1_gnt", 64'(gnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            rd = 2'b01;
            addr[63:0] = 64'(i);
            push_read(1'b0, 8'(i));
            @(negedge CLK);
            check("t1_ram_read", 64'(ram_read), 64'd1);
            check("t1_ram_address", ram_address, 64'(i));
            step();
        end
        rd = '0; req = '0;
        repeat (3) step();
        check("t1_idle_gnt", 64'(gnt), 64'd0);

        // 2: both request from reset; bursts of 16 alternate with no dead cycle.
        do_reset();
        req = 2'b11;
        step();
        for (int c = 0; c <= 32; c++) begin
            logic [1:0] eg;
            eg = (c < 16 || c == 32) ? 2'b01 : 2'b10;
            wr = 2'b11;
            addr[63:0]   = 64'(100 + c);
            addr[127:64] = 64'(200 + c);
            wdata = {32'hB100_0000 + c, 32'hB000_0000 + c};
            @(negedge CLK);
            check("t2_gnt", 64'(gnt), 64'(eg));
            check("t2_ram_write", 64'(ram_write), 64'd1);
            check("t2_ram_address", ram_address, eg[0] ? 64'(100 + c) : 64'(200 + c));
            step();
        end
        wr = '0; req = '0;
        step();

        // 3: master 1 alone writes 40 words and keeps the grant throughout.
        req = 2'b10;
        step();
        step();
        for (int k = 0; k < 40; k++) begin
            wr = 2'b10;
            addr[127:64] = 64'(8'h10 + k);
            wdata[63:32] = 32'hC0DE_0000 + k;
            @(negedge CLK);
            check("t3_gnt", 64'(gnt), 64'd2);
            step();
        end
        wr = '0; req = '0;
        step();
        for (int k = 0; k < 40; k++) begin
            check("t3_mem", 64'(mem[8'(8'h10 + k)]), 64'(32'hC0DE_0000 + k));
        end

        // 4: last read of master 0 returns to it across the handover.
        do_reset();
        req = 2'b01;
        step();
        req = 2'b11; rd = 2'b01; addr[63:0] = 64'd5;
        push_read(1'b0, 8'd5);
        step();
        req = 2'b10; rd = 2'b01; addr[63:0] = 64'd6;
        push_read(1'b0, 8'd6);
        step();
        check("t4_gnt_handover", 64'(gnt), 64'd2);
        check("t4_rvalid_issuer", 64'(rvalid), 64'd1);
        rd = 2'b10; addr[127:64] = 64'd7;
        push_read(1'b1, 8'd7);
        step();
        check("t4_rvalid_m1", 64'(rvalid), 64'd2);
        rd = '0; req = '0;
        repeat (2) step();

        // 5: mux table while master 0 owns the RAM.
        do_reset();
        req = 2'b01;
        step();
        for (int i = 0; i < 8; i++) begin
            rd = {vecs[i].rd1, vecs[i].rd0};
            wr = {vecs[i].wr1, vecs[i].wr0};
            addr[63:0]   = 64'(8'h30 + i);
            addr[127:64] = 64'h0000_0000_0000_00F0;
            wdata = {32'hDEAD_BEEF, 32'h5A00_0000 + i};
            if (vecs[i].exp_read) push_read(1'b0, 8'(8'h30 + i));
            @(negedge CLK);
            check("t5_ram_read", 64'(ram_read), 64'(vecs[i].exp_read));
            check("t5_ram_write", 64'(ram_write), 64'(vecs[i].exp_write));
            check("t5_ram_address", ram_address, 64'(8'h30 + i));
            check("t5_ram_data_in", 64'(ram_data_in), 64'(32'h5A00_0000 + i));
            step();
        end
        rd = '0; wr = '0; req = '0;
        repeat (2) step();
        check("t5_mem_rdwr", 64'(mem[8'h35]), 64'h5A00_0005);

        // 6: asynchronous reset mid-burst with a read return in flight.
        do_reset();
        req = 2'b01;
        step();
        rd = 2'b01; addr[63:0] = 64'd9;
        step();
        #1;
        RST_L = 1'b0;
        #1;
        check("t6_gnt", 64'(gnt), 64'd0);
        check("t6_rvalid", 64'(rvalid), 64'd0);
        check("t6_ram_read", 64'(ram_read), 64'd0);
        check("t6_ram_write", 64'(ram_write), 64'd0);
        check("t6_ram_address", ram_address, 64'd0);
        rd = '0; req = '0;
        @(negedge CLK);
        RST_L = 1'b1;
        step();
        req = 2'b11;
        step();
        check("t6_gnt_after", 64'(gnt), 64'd1);
        req = '0;
        repeat (3) step();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
